// File: rtl/block_drop_animator_pkg.sv
// Shared definitions for the block drop animator.
// Holds the FSM state encoding, screen geometry and coordinate widths used by
// the top level and its frame step counter.
package block_drop_animator_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_MOVE  = 3'd4,
        ST_LAND  = 3'd5
    } state_t;

    // Counter width for a modulo-n counter; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_drop_animator_frame_step_counter.sv
// Counts frame ticks modulo FRAMES_PER_STEP and flags the tick that wraps.
// Ports:
//   clock, resetn  clock and asynchronous active-low reset
//   frame_tick     one-cycle frame pulse
//   enable         count only while high
//   clear          synchronous clear; overrides counting and suppresses step
//   step_c         combinational pulse on the tick that wraps the count to 0
module frame_step_counter
    import block_drop_animator_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic frame_tick,
    input  logic enable,
    input  logic clear,
    output logic step_c
);

    localparam int unsigned      CNT_W = cnt_width(FRAMES_PER_STEP);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAMES_PER_STEP - 1);

    logic [CNT_W-1:0] count_q;
    logic             count_hit;

    assign count_hit = enable && !clear && frame_tick;
    assign step_c    = count_hit && (count_q == LAST);

    // Frame counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_hit) begin
            count_q <= step_c ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/block_drop_animator.sv
// Moves one BLK_W x BLK_W block down the screen, one pixel every
// FRAMES_PER_STEP frame ticks, by erasing it, stepping y and redrawing it.
// Ports:
//   clock, resetn  clock and asynchronous active-low reset
//   frame_tick     one-cycle pulse per frame
//   start          spawn a block at (start_x, 0) in colour_in; honoured in IDLE only
//   x_out, y_out   pixel coordinate to the VGA adapter
//   colour_out     pixel colour (0 while erasing)
//   plot           pixel write strobe, one pixel per cycle
//   busy           high in every state but IDLE
//   landed         one-cycle pulse when the block reaches the floor
// Outputs are decoded from registered state only. BLK_W must be a power of 2, >= 2.
module block_drop_animator
    import block_drop_animator_pkg::*;
#(
    parameter int unsigned BLK_W           = 4,
    parameter int unsigned FRAMES_PER_STEP = 15,
    parameter int unsigned Y_MAX           = 120,
    parameter int unsigned COLOUR_W        = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                frame_tick,
    input  logic                start,
    input  logic [X_W-1:0]      start_x,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                landed
);

    localparam int unsigned    HW     = $clog2(BLK_W);
    localparam int unsigned    PW     = 2 * HW;
    localparam logic [PW-1:0]  P_LAST = PW'(BLK_W * BLK_W - 1);
    localparam logic [Y_W-1:0] Y_LAND = Y_W'(Y_MAX - BLK_W);

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [PW-1:0]       p_q, p_d;
    logic                pending_q, pending_d;
    logic                step_c;
    logic                count_en;
    logic                count_clr;
    logic [HW-1:0]       p_lo;
    logic [HW-1:0]       p_hi;

    assign count_en  = (state_q != ST_IDLE);
    assign count_clr = (state_q == ST_LAND);
    assign p_lo      = p_q[HW-1:0];
    assign p_hi      = p_q[PW-1:HW];

    frame_step_counter #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_frame_step_counter (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .enable     (count_en),
        .clear      (count_clr),
        .step_c     (step_c)
    );

    // State and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            p_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            p_q       <= p_d;
            pending_q <= pending_d;
        end
    end

    // Next-state, datapath updates and output decode
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        p_d        = p_q;
        // A maturity while already pending merges into the existing request.
        pending_d  = pending_q | step_c;
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        plot       = 1'b0;
        busy       = 1'b1;
        landed     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    x_d      = start_x;
                    y_d      = '0;
                    colour_d = colour_in;
                    p_d      = '0;
                    state_d  = ST_DRAW;
                end
            end
            ST_DRAW, ST_ERASE: begin
                // Row-major walk over the block, top-left pixel first.
                plot       = 1'b1;
                x_out      = x_q + X_W'(p_lo);
                y_out      = y_q + Y_W'(p_hi);
                colour_out = (state_q == ST_DRAW) ? colour_q : '0;
                if (p_q == P_LAST) begin
                    p_d     = '0;
                    state_d = (state_q == ST_DRAW) ? ST_WAIT : ST_MOVE;
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            ST_WAIT: begin
                // Servicing clears the request; a step maturing this cycle is dropped.
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = (y_q == Y_LAND) ? ST_LAND : ST_ERASE;
                end
            end
            ST_MOVE: begin
                y_d     = y_q + Y_W'(1);
                state_d = ST_DRAW;
            end
            ST_LAND: begin
                landed  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
